// File: rtl/dpi_flow_ctx_sched.sv
// dpi_flow_ctx_sched: time-shares one DFA engine across byte streams with per-stream saved state
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_vld/data/sop/eop       per-stream byte offer (stream i data at [8i+7:8i])
//   req_rdy                    per-stream byte accepted this cycle
//   eng_char, eng_char_vld     byte to the engine
//   eng_state, eng_state_vld   context load into the engine
//   eng_state_q, eng_accept    engine current state and accept flag
//   match_vld, match_id        registered accept tagged with owning stream
//   busy                       scheduler not idle
module dpi_flow_ctx_sched #(
    parameter int NUM_STREAMS = 4,
    parameter int SW          = 11,
    parameter int BURST       = 16,
    parameter int IDW         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_STREAMS-1:0]   req_vld,
    input  logic [8*NUM_STREAMS-1:0] req_data,
    input  logic [NUM_STREAMS-1:0]   req_sop,
    input  logic [NUM_STREAMS-1:0]   req_eop,
    output logic [NUM_STREAMS-1:0]   req_rdy,
    output logic [7:0]               eng_char,
    output logic                     eng_char_vld,
    output logic [SW-1:0]            eng_state,
    output logic                     eng_state_vld,
    input  logic [SW-1:0]            eng_state_q,
    input  logic                     eng_accept,
    output logic                     match_vld,
    output logic [IDW-1:0]           match_id,
    output logic                     busy
);
    localparam int CW = $clog2(BURST + 1);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, SAVE} state_t;
    state_t         st_q;
    logic [IDW-1:0] ptr_q, grant_q, match_id_q, pick;
    logic [CW-1:0]  cnt_q;
    logic [SW-1:0]  ctx_q [NUM_STREAMS];
    logic           last_eop_q, match_vld_q;
    logic           g_vld, g_sop, g_eop, acc, run_exit;
    logic [7:0]     g_data;
    assign g_vld  = req_vld[grant_q];
    assign g_sop  = req_sop[grant_q];
    assign g_eop  = req_eop[grant_q];
    assign g_data = req_data[8*grant_q +: 8];
    // a packet start may only open a grant; a later sop ends the burst unaccepted
    assign acc      = (st_q == RUN) && g_vld && !(g_sop && cnt_q != '0);
    assign run_exit = !acc || g_eop || cnt_q == CW'(BURST - 1);
    assign req_rdy       = acc ? NUM_STREAMS'(1) << grant_q : '0;
    assign eng_char_vld  = acc;
    assign eng_char      = acc ? g_data : 8'd0;
    assign eng_state_vld = st_q == LOAD;
    assign eng_state     = (st_q == LOAD && !g_sop) ? ctx_q[grant_q] : '0;
    assign match_vld     = match_vld_q;
    assign match_id      = match_id_q;
    assign busy          = st_q != IDLE;
    // round-robin: nearest requester at or after ptr wins
    always_comb begin
        pick = ptr_q;
        for (int k = NUM_STREAMS - 1; k >= 0; k--)
            if (req_vld[(int'(ptr_q) + k) % NUM_STREAMS]) pick = IDW'((int'(ptr_q) + k) % NUM_STREAMS);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            last_eop_q  <= 1'b0;
            match_vld_q <= 1'b0;
            match_id_q  <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) ctx_q[i] <= '0;
        end else begin
            match_vld_q <= eng_char_vld && eng_accept;
            match_id_q  <= grant_q;
            case (st_q)
                IDLE: if (|req_vld) begin
                    grant_q <= pick;
                    st_q    <= LOAD;
                end
                LOAD: begin
                    cnt_q      <= '0;
                    last_eop_q <= 1'b0;
                    st_q       <= RUN;
                end
                RUN: begin
                    if (acc) begin
                        cnt_q      <= cnt_q + 1'b1;
                        last_eop_q <= g_eop;
                    end
                    if (run_exit) st_q <= SAVE;
                end
                default: begin
                    // a finished packet leaves a clean context for the next one
                    ctx_q[grant_q] <= last_eop_q ? '0 : eng_state_q;
                    ptr_q          <= (grant_q == IDW'(NUM_STREAMS - 1)) ? '0 : grant_q + 1'b1;
                    st_q           <= IDLE;
                end
            endcase
        end
    end
endmodule
